// File: rtl/snake_motion_pkg.sv
// Shared types and constants for the snake motion block: movement
// directions, the cell coordinate pair, playfield size and the
// start-of-game snake position.
package snake_motion_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    // One playfield cell; 4-bit column and row are enough for 16x15.
    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } cell_t;

    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 15;

    // Start-of-game snake: head at (7,7) heading right, body trailing left.
    localparam int RESET_COL = 7;
    localparam int RESET_ROW = 7;
    localparam int RESET_LEN = 3;

    // Direction that would fold the head straight back onto segment 1.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t o;
        case (d)
            LEFT:    o = RIGHT;
            RIGHT:   o = LEFT;
            UP:      o = DOWN;
            default: o = UP;
        endcase
        return o;
    endfunction

    // Neighbouring cell in direction d, wrapping at every playfield edge.
    function automatic cell_t advance_cell(input cell_t c, input dir_t d);
        cell_t n;
        n = c;
        case (d)
            LEFT:    n.col = (c.col == 4'd0) ? 4'(GRID_COLS - 1) : c.col - 4'd1;
            RIGHT:   n.col = (c.col == 4'(GRID_COLS - 1)) ? 4'd0 : c.col + 4'd1;
            UP:      n.row = (c.row == 4'd0) ? 4'(GRID_ROWS - 1) : c.row - 4'd1;
            default: n.row = (c.row == 4'(GRID_ROWS - 1)) ? 4'd0 : c.row + 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/snake_dir_ctrl.sv
// Player steering: decodes the switch bank with a fixed priority, drops
// requests that would reverse the snake, and holds the accepted request
// until the next movement step picks it up.
module snake_dir_ctrl
    import snake_motion_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] switches,
    input  dir_t       dir,
    output dir_t       pending
);

    dir_t pending_reg;
    dir_t req_dir;
    logic req_valid;
    logic unused_switch_bits;

    // Only the low nibble carries controls.
    assign unused_switch_bits = ^switches[7:4];

    // Priority decode: left beats right beats up beats down.
    always_comb begin
        req_dir   = RIGHT;
        req_valid = 1'b1;
        if (switches[0]) begin
            req_dir = LEFT;
        end else if (switches[1]) begin
            req_dir = RIGHT;
        end else if (switches[2]) begin
            req_dir = UP;
        end else if (switches[3]) begin
            req_dir = DOWN;
        end else begin
            req_valid = 1'b0;
        end
    end

    // Pending direction: take the winning request unless it reverses the
    // current heading; a reversal is dropped rather than falling through
    // to a lower-priority switch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_reg <= RIGHT;
        end else if (req_valid && (req_dir != opposite_dir(dir))) begin
            pending_reg <= req_dir;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/snake_motion.sv
// Snake movement engine: frame-paced stepping on a wrapping 16x15 cell
// grid, a shift-register body of up to MAX_LEN cells, growth requests,
// self-collision detection and a combinational body-pixel lookup for
// the video path.
module snake_motion
    import snake_motion_pkg::*;
#(
    parameter int SNAKE_SIZE  = 16,
    parameter int SNAKE_SPEED = 5,
    parameter int MAX_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic [7:0] switches,
    input  logic       grow,
    output logic [8:0] head_x,
    output logic [8:0] head_y,
    output logic       snake_pixel,
    output logic       dead,
    output logic       step
);

    localparam int SHIFT  = $clog2(SNAKE_SIZE);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int CNT_W  = (SNAKE_SPEED > 1) ? $clog2(SNAKE_SPEED) : 1;
    localparam int FIELD_W = GRID_COLS * SNAKE_SIZE;
    localparam int FIELD_H = GRID_ROWS * SNAKE_SIZE;

    // Segment 0 is the head; higher indices trail behind it. Entries past
    // the live length keep shifting so a grow exposes the most recent
    // tail position.
    cell_t             seg_reg [MAX_LEN];
    dir_t              dir_reg;
    dir_t              pending;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  len_next;
    logic [CNT_W-1:0]  frame_cnt_reg;
    logic              dead_reg;
    logic              step_reg;

    logic              frame_tick;
    logic              move;
    cell_t             head_next;
    logic              collide;
    logic [MAX_LEN-1:0] coll_hit;
    logic [MAX_LEN-1:0] pix_hit;
    cell_t             pix_cell;
    logic              in_field;

    snake_dir_ctrl u_dir_ctrl (
        .clk      (clk),
        .reset    (reset),
        .switches (switches),
        .dir      (dir_reg),
        .pending  (pending)
    );

    // Frame pacing: one tick per frame at the first blanking line; a move
    // fires on the last tick of each SNAKE_SPEED-frame period.
    always_comb begin
        frame_tick = (vpos == 9'(FIELD_H)) && (hpos == 9'd0);
        move       = frame_tick && (frame_cnt_reg == CNT_W'(SNAKE_SPEED - 1)) && !dead_reg;
    end

    // Next head cell and next length; a grow arriving with a move is
    // already counted in the collision check of that move.
    always_comb begin
        head_next = advance_cell(seg_reg[0], pending);
        len_next  = len_reg;
        if (grow && (len_reg < LEN_W'(MAX_LEN))) begin
            len_next = len_reg + LEN_W'(1);
        end
    end

    // After the shift, body segment i holds today's segment i-1, so the
    // new head is compared against the pre-shift cells 0..len-2.
    assign coll_hit[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_coll
            assign coll_hit[gi] = (LEN_W'(gi) < len_next) && (seg_reg[gi-1] == head_next);
        end
    endgenerate
    assign collide = |coll_hit;

    // Control state: frame counter, heading, length, death flag and the
    // step strobe, all released together on the move edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_reg <= '0;
            dir_reg       <= RIGHT;
            len_reg       <= LEN_W'(RESET_LEN);
            dead_reg      <= 1'b0;
            step_reg      <= 1'b0;
        end else begin
            step_reg <= move;
            if (frame_tick) begin
                if (frame_cnt_reg == CNT_W'(SNAKE_SPEED - 1)) begin
                    frame_cnt_reg <= '0;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                end
            end
            if (move) begin
                dir_reg <= pending;
                if (collide) begin
                    dead_reg <= 1'b1;
                end
            end
            if (!dead_reg) begin
                len_reg <= len_next;
            end
        end
    end

    // Body history: on each move every segment takes its predecessor's
    // cell and the head takes the advanced cell.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_reg[i].col <= 4'(RESET_COL - i);
                seg_reg[i].row <= 4'(RESET_ROW);
            end
        end else if (move) begin
            seg_reg[0] <= head_next;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_reg[i] <= seg_reg[i-1];
            end
        end
    end

    // Pixel lookup: map the beam position to a cell and test it against
    // every live segment. Positions outside the playfield never light,
    // which also stops the 4-bit cell index from aliasing.
    always_comb begin
        in_field     = (hpos < 9'(FIELD_W)) && (vpos < 9'(FIELD_H));
        pix_cell.col = 4'(hpos >> SHIFT);
        pix_cell.row = 4'(vpos >> SHIFT);
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pix
            assign pix_hit[gi] = (LEN_W'(gi) < len_reg) && (seg_reg[gi] == pix_cell);
        end
    endgenerate

    assign snake_pixel = in_field && (|pix_hit);
    assign head_x      = 9'(seg_reg[0].col) << SHIFT;
    assign head_y      = 9'(seg_reg[0].row) << SHIFT;
    assign dead        = dead_reg;
    assign step        = step_reg;

endmodule

// File: tb/tb_snake_motion.sv
// Directed bench for snake_motion: reset state, frame pacing, reversal
// rejection, wrap-around, growth saturation, self-collision freeze and
// reset overriding a move.
module tb_snake_motion;

    logic       clk;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic [7:0] switches;
    logic       grow;
    logic [8:0] head_x;
    logic [8:0] head_y;
    logic       snake_pixel;
    logic       dead;
    logic       step;

    int checks = 0;
    int errors = 0;

    snake_motion #(
        .SNAKE_SIZE  (16),
        .SNAKE_SPEED (5),
        .MAX_LEN     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .switches    (switches),
        .grow        (grow),
        .head_x      (head_x),
        .head_y      (head_y),
        .snake_pixel (snake_pixel),
        .dead        (dead),
        .step        (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("check %s: %0d", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_beam();
        hpos = 9'd300;
        vpos = 9'd0;
    endtask

    // Issue n frame ticks; report how many step pulses were seen and the
    // step value right after the last tick.
    task automatic frames(input int n, output int ns, output int ls);
        ns = 0;
        ls = 0;
        for (int k = 0; k < n; k++) begin
            vpos = 9'd240;
            hpos = 9'd0;
            cyc();
            ls = int'(step);
            if (step) begin
                ns++;
                $display("step: head_x=%0d head_y=%0d dead=%0d", head_x, head_y, dead);
            end
            idle_beam();
        end
    endtask

    task automatic lit_at(input int c, input int r, output int v);
        hpos = 9'(c * 16 + 8);
        vpos = 9'(r * 16 + 8);
        #1;
        v = int'(snake_pixel);
        idle_beam();
    endtask

    task automatic count_lit(output int n);
        int v;
        n = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 16; c++) begin
                lit_at(c, r, v);
                n += v;
            end
        end
    endtask

    task automatic set_sw(input logic [7:0] s);
        switches = s;
        cyc();
        switches = 8'h00;
        cyc();
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        cyc();
        grow = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns;
        int ls;
        int n;
        int v;

        reset    = 1'b0;
        switches = 8'h00;
        grow     = 1'b0;
        idle_beam();
        cyc();
        cyc();
        chk("step_in_reset", step, 0);
        reset = 1'b1;
        cyc();

        // Reset state
        chk("rst_head_x", head_x, 112);
        chk("rst_head_y", head_y, 112);
        chk("rst_dead", dead, 0);
        chk("rst_step", step, 0);
        count_lit(n);
        chk("rst_lit_count", n, 3);
        lit_at(5, 7, v);
        chk("rst_tail_lit", v, 1);
        lit_at(4, 7, v);
        chk("rst_past_tail_dark", v, 0);

        // Five frames give exactly one move
        frames(4, ns, ls);
        chk("no_step_4_ticks", ns, 0);
        frames(1, ns, ls);
        chk("step_on_5th_tick", ns, 1);
        chk("first_move_x", head_x, 128);
        chk("first_move_y", head_y, 112);
        cyc();
        chk("step_one_cycle", step, 0);

        // Reversal rejection
        set_sw(8'h01);
        frames(5, ns, ls);
        chk("rev_left_x", head_x, 144);
        chk("rev_left_y", head_y, 112);
        set_sw(8'h05);
        frames(5, ns, ls);
        chk("rev_prio_x", head_x, 160);
        chk("rev_prio_y", head_y, 112);

        // Run to column 15, then wrap
        frames(25, ns, ls);
        chk("run_steps", ns, 5);
        chk("col15_x", head_x, 240);
        frames(5, ns, ls);
        chk("wrap_x", head_x, 0);
        chk("wrap_y", head_y, 112);
        lit_at(0, 7, v);
        chk("wrap_head_lit", v, 1);
        hpos = 9'd264;
        vpos = 9'd120;
        #1;
        chk("pix_h_out_of_field", snake_pixel, 0);
        hpos = 9'd8;
        vpos = 9'd376;
        #1;
        chk("pix_v_out_of_field", snake_pixel, 0);
        idle_beam();

        // Grow saturation
        repeat (10) pulse_grow();
        count_lit(n);
        chk("grow_lit_count", n, 8);
        frames(40, ns, ls);
        chk("grow_run_steps", ns, 8);
        chk("grow_run_x", head_x, 128);
        count_lit(n);
        chk("grow_moved_lit", n, 8);
        lit_at(1, 7, v);
        chk("grow_tail_lit", v, 1);
        lit_at(0, 7, v);
        chk("grow_past_tail_dark", v, 0);

        // Self-collision with length 5
        do_reset();
        pulse_grow();
        pulse_grow();
        count_lit(n);
        chk("len5_lit_count", n, 5);
        set_sw(8'h08);
        frames(5, ns, ls);
        chk("turn_down_x", head_x, 112);
        chk("turn_down_y", head_y, 128);
        set_sw(8'h01);
        frames(5, ns, ls);
        chk("turn_left_x", head_x, 96);
        chk("turn_left_y", head_y, 128);
        chk("alive_before_hit", dead, 0);
        set_sw(8'h04);
        frames(5, ns, ls);
        chk("hit_step", ls, 1);
        chk("hit_dead", dead, 1);
        chk("hit_x", head_x, 96);
        chk("hit_y", head_y, 112);
        frames(10, ns, ls);
        chk("dead_no_steps", ns, 0);
        chk("dead_x_frozen", head_x, 96);
        chk("dead_y_frozen", head_y, 112);
        chk("dead_sticky", dead, 1);
        pulse_grow();
        count_lit(n);
        chk("dead_frozen_lit", n, 4);

        // Reset coincident with a move and a grow
        do_reset();
        chk("rerst_dead", dead, 0);
        frames(4, ns, ls);
        chk("rerst_no_step_4", ns, 0);
        reset = 1'b0;
        grow  = 1'b1;
        vpos  = 9'd240;
        hpos  = 9'd0;
        cyc();
        chk("rst_move_step", step, 0);
        chk("rst_move_x", head_x, 112);
        chk("rst_move_y", head_y, 112);
        chk("rst_move_dead", dead, 0);
        grow  = 1'b0;
        idle_beam();
        reset = 1'b1;
        cyc();
        count_lit(n);
        chk("rst_grow_lit", n, 3);
        frames(4, ns, ls);
        chk("cnt_restart_4", ns, 0);
        frames(1, ns, ls);
        chk("cnt_restart_5", ns, 1);
        chk("cnt_restart_x", head_x, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_motion.md
SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 Parameter SNAKE_SIZE, default 16, cell edge in pixels.
REQ-002 Parameter SNAKE_SPEED, default 5, frames per movement step.
REQ-003 Parameter MAX_LEN, default 8, maximum segments including head.
REQ-004 Port clk  input  1  pixel clock; the only clock.
REQ-005 Port reset  input  1  reset; synchronous, active-low.
REQ-006 Port hpos  input  9  horizontal pixel position from the sync generator.
REQ-007 Port vpos  input  9  vertical pixel position from the sync generator.
REQ-008 Port switches  input  8  player controls; bit0 left, bit1 right, bit2 up, bit3 down, active-high; bits 7:4 ignored.
REQ-009 Port grow  input  1  one-cycle request to add one segment.
REQ-010 Port head_x  output  9  head left edge in pixels, equal to head column * SNAKE_SIZE.
REQ-011 Port head_y  output  9  head top edge in pixels, equal to head row * SNAKE_SIZE.
REQ-012 Port snake_pixel  output  1  high when (hpos,vpos) lies inside any live segment cell.
REQ-013 Port dead  output  1  sticky self-collision flag.
REQ-014 Port step  output  1  one-cycle pulse on each cycle the head moves.

Function
REQ-015 Playfield SHALL be 16 columns x 15 rows of cells (256x240 pixels).
REQ-016 Frame tick SHALL be a one-cycle pulse when vpos==240 and hpos==0.
REQ-017 Frame counter SHALL count ticks 0..SNAKE_SPEED-1; a move SHALL occur on the tick where the count is SNAKE_SPEED-1, and the count SHALL then return to 0.
REQ-018 Pending direction SHALL be sampled every cycle; priority is left > right > up > down; no active bit keeps the pending direction.
REQ-019 A request opposite to the current direction SHALL be ignored.
REQ-020 Current direction SHALL load from pending direction only on a move cycle.
REQ-021 On a move, segment history SHALL shift by one (segment i <= segment i-1), and the head SHALL advance one cell.
REQ-022 Wrap-around: column 15 moving right becomes 0; column 0 moving left becomes 15; row 14 moving down becomes 0; row 0 moving up becomes 14.
REQ-023 Length SHALL increment by 1 on grow, saturating at MAX_LEN; grow coincident with a move SHALL take effect on that move.
REQ-024 Self-collision SHALL be detected when the new head cell equals any segment 1..length-1 after the shift; dead SHALL be set in the same cycle that step pulses.
REQ-025 While dead is high, there SHALL be no moves, no step pulses, and no length change; snake_pixel SHALL still reflect the frozen segments.
REQ-026 snake_pixel SHALL be combinational from hpos, vpos and the registered segments, and SHALL be low for hpos>=256 or vpos>=240.
REQ-027 Segment cell arithmetic SHALL use 4-bit column/row values; pixel outputs SHALL be zero-extended shifts by log2(SNAKE_SIZE).

Reset
REQ-028 On reset low at a clock edge:
  - head = column 7, row 7 (head_x=112, head_y=112);
  - length = 3, with segments 1 and 2 at columns 6 and 5, row 7;
  - direction and pending direction = right;
  - frame count = 0;
  - dead = 0, step = 0.
REQ-029 Reset asserted mid-operation SHALL override a coincident move or grow.

Structure
REQ-030 A shared package SHALL hold the direction enum (LEFT, RIGHT, UP, DOWN), the grid constants (GRID_COLS=16, GRID_ROWS=15) and the reset cell constants.
REQ-031 A sub-module snake_dir_ctrl SHALL hold the priority decode, reversal rejection and pending-direction register.
REQ-032 Segments SHALL be an array of MAX_LEN column/row registers; entries at index >= length SHALL be ignored for both collision and pixel output.

Verification
REQ-033 Reset, no input, 5 frame ticks -> exactly one step; head_x=128, head_y=112.
REQ-034 Head at column 15 moving right, one move -> head_x=0, head_y unchanged.
REQ-035 Direction right, switches=8'h01 (left) -> direction stays right; switches=8'h05 (left and up) -> no turn, because left wins priority and is rejected as a reversal.
REQ-036 grow pulsed 10 times -> length saturates at 8; after 8 moves, 8 distinct cells are lit on snake_pixel.
REQ-037 Length 5; steer down, left, up on consecutive moves -> dead=1 on the third move; afterwards step stays 0 and head_x/head_y stay constant.
REQ-038 Reset low on the same cycle as a move -> outputs equal the reset values, and step=0.
